// File: rtl/core_defs.sv
// Shared definitions for the instruction-fetch path: opcodes, reset/exception
// addresses and the next-PC source encoding.
package core_defs;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0004;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_JMP,
        NPC_JR,
        NPC_BR,
        NPC_EXC,
        NPC_HOLD
    } npc_sel_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

    function automatic logic is_jump_op(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-stage bus: instruction memory port, hazard/redirect inputs and the
// IF/ID register outputs seen by the decode stage.
interface fetch_controller_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        jr_valid;
    logic [31:0] jr_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exception;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        squash_id;
    logic [31:0] epc;

    modport master (
        output imem_addr, if_id_instr, if_id_pc4, if_id_valid, squash_id, epc,
        input  imem_instr, stall, jr_valid, jr_target, br_taken, br_target, exception
    );

    modport slave (
        input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, squash_id, epc,
        output imem_instr, stall, jr_valid, jr_target, br_taken, br_target, exception
    );

endinterface

// File: rtl/npc_select.sv
// Combinational next-PC priority mux: exception > branch > stall > jr > jump > sequential.
module npc_select
    import core_defs::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VECTOR
) (
    input  logic [31:0] pc_i,
    input  logic [31:0] if_id_instr_i,
    input  logic [3:0]  if_id_pc4_hi_i,
    input  logic        if_id_valid_i,
    input  logic        stall_i,
    input  logic        jr_valid_i,
    input  logic [31:0] jr_target_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        exception_i,
    output npc_sel_e    sel_o,
    output logic [31:0] npc_o,
    output logic        bubble_o,
    output logic        squash_o
);

    logic        jmp_id;
    logic [31:0] jmp_target;

    assign jmp_id     = if_id_valid_i && is_jump_op(if_id_instr_i[31:26]);
    assign jmp_target = {if_id_pc4_hi_i, if_id_instr_i[25:0], 2'b00};

    always_comb begin
        sel_o    = NPC_SEQ;
        npc_o    = pc_i + 32'd4;
        bubble_o = 1'b0;
        squash_o = 1'b0;
        if (exception_i) begin
            sel_o    = NPC_EXC;
            npc_o    = word_align(EXC_VEC);
            bubble_o = 1'b1;
            squash_o = 1'b1;
        end else if (br_taken_i) begin
            sel_o    = NPC_BR;
            npc_o    = word_align(br_target_i);
            bubble_o = 1'b1;
            squash_o = 1'b1;
        end else if (stall_i) begin
            // Stall also masks ID-stage redirects until the hazard clears.
            sel_o    = NPC_HOLD;
            npc_o    = pc_i;
        end else if (jr_valid_i) begin
            sel_o    = NPC_JR;
            npc_o    = word_align(jr_target_i);
            bubble_o = 1'b1;
        end else if (jmp_id) begin
            sel_o    = NPC_JMP;
            npc_o    = jmp_target;
            bubble_o = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: PC register, IF/ID pipeline register and EPC capture.
// Next-PC choice is delegated to npc_select.
module fetch_controller #(
    parameter logic [31:0] RESET_PC   = core_defs::RESET_PC,
    parameter logic [31:0] EXC_VECTOR = core_defs::EXC_VECTOR,
    parameter logic [31:0] NOP_WORD   = core_defs::NOP_WORD
) (
    input logic                clk,
    input logic                reset,
    fetch_controller_if.master bus
);

    core_defs::npc_sel_e sel;
    logic [31:0]         npc;
    logic                bubble;
    logic                squash;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] epc_q, epc_d;

    npc_select #(
        .EXC_VEC (EXC_VECTOR)
    ) u_npc_select (
        .pc_i           (pc_q),
        .if_id_instr_i  (instr_q),
        .if_id_pc4_hi_i (pc4_q[31:28]),
        .if_id_valid_i  (valid_q),
        .stall_i        (bus.stall),
        .jr_valid_i     (bus.jr_valid),
        .jr_target_i    (bus.jr_target),
        .br_taken_i     (bus.br_taken),
        .br_target_i    (bus.br_target),
        .exception_i    (bus.exception),
        .sel_o          (sel),
        .npc_o          (npc),
        .bubble_o       (bubble),
        .squash_o       (squash)
    );

    always_comb begin
        pc_d    = npc;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        epc_d   = epc_q;
        if (sel != core_defs::NPC_HOLD) begin
            if (bubble) begin
                instr_d = NOP_WORD;
                pc4_d   = 32'd0;
                valid_d = 1'b0;
            end else begin
                instr_d = bus.imem_instr;
                pc4_d   = npc;
                valid_d = 1'b1;
            end
        end
        // Oldest squashed instruction is the one in ID if live, else the one being fetched.
        if (sel == core_defs::NPC_EXC) begin
            epc_d = valid_q ? (pc4_q - 32'd4) : pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            epc_q   <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            epc_q   <= epc_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc4   = pc4_q;
    assign bus.if_id_valid = valid_q;
    assign bus.squash_id   = squash;
    assign bus.epc         = epc_q;

endmodule
